// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// fills the IF/ID pipeline register. Handles stalls, redirects and a fetch counter.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_inst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_ADVANCE
    } fetch_act_e;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

    fetch_act_e       act;
    logic [31:0]      pc_plus4;
    logic [31:0]      pc_next;
    logic [31:0]      inst_next;
    logic [31:0]      ipc_next;
    logic [31:0]      ipc4_next;
    logic             valid_next;
    logic [CNT_W-1:0] cnt_next;

    // The ROM has no latency, so its address is simply the live PC.
    assign rom_addr = pc;
    assign pc_plus4 = pc + 32'd4;

    // Fixed priority: rst > redirect > stall > advance.
    always_comb begin
        if (rst)
            act = ACT_RESET;
        else if (redirect)
            act = ACT_REDIRECT;
        else if (stall)
            act = ACT_STALL;
        else
            act = ACT_ADVANCE;
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_next    = pc;
        inst_next  = if_id_inst;
        ipc_next   = if_id_pc;
        ipc4_next  = if_id_pc4;
        valid_next = if_id_valid;
        cnt_next   = fetch_cnt;
        unique case (act)
            ACT_RESET: begin
                pc_next    = RESET_WORD;
                inst_next  = NOP;
                ipc_next   = '0;
                ipc4_next  = '0;
                valid_next = 1'b0;
                cnt_next   = '0;
            end
            ACT_REDIRECT: begin
                // Flush the wrong-path word with a bubble; the counter only
                // tracks real fetches.
                pc_next    = {redirect_pc[31:2], 2'b00};
                inst_next  = NOP;
                ipc_next   = '0;
                ipc4_next  = '0;
                valid_next = 1'b0;
            end
            ACT_STALL: begin
            end
            ACT_ADVANCE: begin
                pc_next    = pc_plus4;
                inst_next  = rom_inst;
                ipc_next   = pc;
                ipc4_next  = pc_plus4;
                valid_next = 1'b1;
                cnt_next   = fetch_cnt + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        pc          <= pc_next;
        if_id_inst  <= inst_next;
        if_id_pc    <= ipc_next;
        if_id_pc4   <= ipc4_next;
        if_id_valid <= valid_next;
        fetch_cnt   <= cnt_next;
    end

endmodule
